jtframe_mr_ddrload: RTL and testbench

Fast ROM loader for MiSTer builds. It reads a ROM image that the HPS has already placed in DDR, using Avalon-MM read bursts, and buffers the returned 64-bit words. It unpacks them into a byte stream on the standard prog_* download bus. It sits directly upstream of jtframe_mr_ddrmux and drives that block's ddrld_* inputs. It also owns the `downloading` flag that the mux uses to select DDR ownership.

---
 rtl/jtframe_ddrload_pkg.sv | 21 ++
 rtl/jtframe_ddrload_fifo.sv | 69 ++++++
 rtl/jtframe_mr_ddrload.sv | 230 +++++++++++++++++++++++
 tb/tb_jtframe_mr_ddrload.sv | 358 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/jtframe_ddrload_pkg.sv
// Shared types and limits for the DDR ROM loader (jtframe_mr_ddrload and its FIFO).
package jtframe_ddrload_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StReq,
        StRecv,
        StWroom,
        StFlush
    } state_e;

    localparam logic [28:0] DdrBaseDefault = 29'h0600_0000;
    localparam int unsigned BurstMin       = 1;
    localparam int unsigned BurstMax       = 128;

    // Length of the next request: a full burst, or whatever is left of the image.
    function automatic logic [7:0] burst_len(input logic [24:0] wleft, input logic [7:0] burst);
        return (wleft < {17'd0, burst}) ? wleft[7:0] : burst;
    endfunction

endpackage

// File: rtl/jtframe_ddrload_fifo.sv
// Single-clock synchronous FIFO with fall-through read data and a free-slot count.
module jtframe_ddrload_fifo #(
    parameter int unsigned Depth = 16,
    parameter int unsigned Width = 64
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           wr_i,
    input  logic [Width-1:0]               wdata_i,
    input  logic                           rd_i,
    output logic [Width-1:0]               rdata_o,
    output logic                           empty_o,
    output logic [$clog2(Depth + 1)-1:0]   free_o
);

    localparam int unsigned CntW = $clog2(Depth + 1);
    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam logic [PtrW-1:0] LastPtr = PtrW'(Depth - 1);
    localparam logic [CntW-1:0] DepthCnt = CntW'(Depth);

    logic [Width-1:0] mem_q [Depth];
    logic [PtrW-1:0]  wptr_q, wptr_d;
    logic [PtrW-1:0]  rptr_q, rptr_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             wr_en, rd_en, full;

    assign full    = (cnt_q == DepthCnt);
    assign empty_o = (cnt_q == '0);
    assign free_o  = DepthCnt - cnt_q;
    assign rdata_o = mem_q[rptr_q];
    assign wr_en   = wr_i & ~full;
    assign rd_en   = rd_i & ~empty_o;

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        cnt_d  = cnt_q;
        if (wr_en) begin
            wptr_d = (wptr_q == LastPtr) ? '0 : wptr_q + 1'b1;
        end
        if (rd_en) begin
            rptr_d = (rptr_q == LastPtr) ? '0 : rptr_q + 1'b1;
        end
        if (wr_en && !rd_en) begin
            cnt_d = cnt_q + 1'b1;
        end else if (!wr_en && rd_en) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            mem_q[wptr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/jtframe_mr_ddrload.sv
// Fast MiSTer ROM loader: bursts an image out of DDR and replays it on the prog_* byte bus.
// Define JTFRAME_DDRLOAD_CHKSUM_EN to accumulate an additive checksum of delivered bytes.
module jtframe_mr_ddrload
    import jtframe_ddrload_pkg::*;
#(
    parameter int unsigned BURST    = 8,
    parameter logic [28:0] DDR_BASE = DdrBaseDefault
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [26:0] len,
    output logic        downloading,
    output logic        done,
    output logic [7:0]  ddrld_burstcnt,
    output logic [28:0] ddrld_addr,
    output logic        ddrld_rd,
    output logic [7:0]  ddrld_be,
    input  logic        ddr_busy,
    input  logic [63:0] ddr_dout,
    input  logic        ddr_dout_ready,
    output logic [26:0] prog_addr,
    output logic [7:0]  prog_data,
    output logic        prog_we,
    input  logic        prog_rdy,
    output logic [15:0] chksum
);

    localparam int unsigned BurstEff  = (BURST < BurstMin) ? BurstMin :
                                        (BURST > BurstMax) ? BurstMax : BURST;
    localparam int unsigned FifoDepth = 2 * BurstEff;
    localparam int unsigned CntW      = $clog2(FifoDepth + 1);
    localparam logic [7:0]      BurstLen    = 8'(BurstEff);
    localparam logic [CntW-1:0] FreeReq     = CntW'(BurstEff);
    localparam logic [CntW-1:0] FreeAfterWr = CntW'(BurstEff + 1);

    state_e      state_q, state_d;
    logic [26:0] len_q, len_d;
    logic [24:0] wleft_q, wleft_d;
    logic [28:0] raddr_q, raddr_d;
    logic [7:0]  burst_q, burst_d;
    logic [7:0]  beats_q, beats_d;
    logic        dl_q, dl_d;
    logic        done_q, done_d;
    logic [63:0] word_q, word_d;
    logic        word_vld_q, word_vld_d;
    logic [26:0] prog_addr_q, prog_addr_d;

    logic            fifo_wr, fifo_rd, fifo_empty;
    logic [63:0]     fifo_rdata;
    logic [CntW-1:0] fifo_free;

    logic        start_ok, accept, byte_last, word_end, last_beat;
    logic [27:0] len_rnd;
    logic [24:0] len_words;
    logic [7:0]  burst_now;

    assign len_rnd   = {1'b0, len} + 28'd7;
    assign len_words = len_rnd[27:3];
    assign burst_now = burst_len(wleft_q, BurstLen);

    assign start_ok  = start & ~dl_q & (state_q == StIdle);
    // Beats arriving outside RECV are stale (e.g. a burst cut short by reset).
    assign fifo_wr   = ddr_dout_ready & (state_q == StRecv);
    assign last_beat = fifo_wr & ((beats_q + 8'd1) == burst_q);

    assign accept    = word_vld_q & prog_rdy;
    assign byte_last = (prog_addr_q + 27'd1) == len_q;
    assign word_end  = accept & ((&prog_addr_q[2:0]) | byte_last);
    // Refill in the same cycle the last byte of a word goes out to keep 1 byte/cycle.
    assign fifo_rd   = dl_q & ~fifo_empty & (~word_vld_q | word_end);

    jtframe_ddrload_fifo #(
        .Depth (FifoDepth),
        .Width (64)
    ) u_fifo (
        .clk_i   (clk),
        .rst_i   (rst),
        .wr_i    (fifo_wr),
        .wdata_i (ddr_dout),
        .rd_i    (fifo_rd),
        .rdata_o (fifo_rdata),
        .empty_o (fifo_empty),
        .free_o  (fifo_free)
    );

    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        wleft_d     = wleft_q;
        raddr_d     = raddr_q;
        burst_d     = burst_q;
        beats_d     = beats_q;
        dl_d        = dl_q;
        done_d      = 1'b0;
        word_d      = word_q;
        word_vld_d  = word_vld_q;
        prog_addr_d = prog_addr_q;

        if (accept) begin
            prog_addr_d = prog_addr_q + 27'd1;
        end
        if (fifo_rd) begin
            word_d     = fifo_rdata;
            word_vld_d = 1'b1;
        end else if (word_end) begin
            word_vld_d = 1'b0;
        end

        case (state_q)
            StIdle: begin
                if (start_ok) begin
                    len_d       = len;
                    wleft_d     = len_words;
                    raddr_d     = DDR_BASE;
                    prog_addr_d = '0;
                    word_vld_d  = 1'b0;
                    if (len != '0) begin
                        state_d = StReq;
                        dl_d    = 1'b1;
                    end else begin
                        done_d  = 1'b1;
                    end
                end
            end
            StReq: begin
                if (!ddr_busy) begin
                    raddr_d = raddr_q + {21'd0, burst_now};
                    wleft_d = wleft_q - {17'd0, burst_now};
                    burst_d = burst_now;
                    beats_d = '0;
                    state_d = StRecv;
                end
            end
            StRecv: begin
                if (fifo_wr) begin
                    beats_d = beats_q + 8'd1;
                end
                if (last_beat) begin
                    if (wleft_q == '0) begin
                        state_d = StFlush;
                    end else if (fifo_free >= FreeAfterWr) begin
                        state_d = StReq;
                    end else begin
                        state_d = StWroom;
                    end
                end
            end
            StWroom: begin
                if (fifo_free >= FreeReq) begin
                    state_d = StReq;
                end
            end
            StFlush: begin
                if (accept && byte_last) begin
                    state_d = StIdle;
                    dl_d    = 1'b0;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            len_q       <= '0;
            wleft_q     <= '0;
            raddr_q     <= DDR_BASE;
            burst_q     <= '0;
            beats_q     <= '0;
            dl_q        <= 1'b0;
            done_q      <= 1'b0;
            word_q      <= '0;
            word_vld_q  <= 1'b0;
            prog_addr_q <= '0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            wleft_q     <= wleft_d;
            raddr_q     <= raddr_d;
            burst_q     <= burst_d;
            beats_q     <= beats_d;
            dl_q        <= dl_d;
            done_q      <= done_d;
            word_q      <= word_d;
            word_vld_q  <= word_vld_d;
            prog_addr_q <= prog_addr_d;
        end
    end

    assign downloading    = dl_q;
    assign done           = done_q;
    assign ddrld_be       = 8'hFF;
    assign ddrld_addr     = raddr_q;
    assign ddrld_rd       = (state_q == StReq);
    assign ddrld_burstcnt = ddrld_rd ? burst_now : 8'd0;
    assign prog_addr      = prog_addr_q;
    assign prog_we        = word_vld_q;
    assign prog_data      = word_q[{prog_addr_q[2:0], 3'b000} +: 8];

`ifdef JTFRAME_DDRLOAD_CHKSUM_EN
    logic [15:0] chksum_q, chksum_d;

    always_comb begin
        chksum_d = chksum_q;
        if (start_ok) begin
            chksum_d = '0;
        end else if (accept) begin
            chksum_d = chksum_q + {8'd0, prog_data};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            chksum_q <= '0;
        end else begin
            chksum_q <= chksum_d;
        end
    end

    assign chksum = chksum_q;
`else
    assign chksum = '0;
`endif

endmodule

// File: tb/tb_jtframe_mr_ddrload.sv
// Directed bench for jtframe_mr_ddrload with a DDR responder and a byte consumer.
`timescale 1ns/1ps
module tb_jtframe_mr_ddrload;

    localparam logic [28:0] Base = 29'h0600_0000;

    logic        clk = 1'b0;
    logic        rst, start;
    logic [26:0] len;
    logic        downloading, done;
    logic [7:0]  ddrld_burstcnt, ddrld_be;
    logic [28:0] ddrld_addr;
    logic        ddrld_rd, ddr_busy, ddr_dout_ready;
    logic [63:0] ddr_dout;
    logic [26:0] prog_addr;
    logic [7:0]  prog_data;
    logic        prog_we, prog_rdy;
    logic [15:0] chksum;

    always #5 clk = ~clk;

    jtframe_mr_ddrload #(
        .BURST    (8),
        .DDR_BASE (Base)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .len            (len),
        .downloading    (downloading),
        .done           (done),
        .ddrld_burstcnt (ddrld_burstcnt),
        .ddrld_addr     (ddrld_addr),
        .ddrld_rd       (ddrld_rd),
        .ddrld_be       (ddrld_be),
        .ddr_busy       (ddr_busy),
        .ddr_dout       (ddr_dout),
        .ddr_dout_ready (ddr_dout_ready),
        .prog_addr      (prog_addr),
        .prog_data      (prog_data),
        .prog_we        (prog_we),
        .prog_rdy       (prog_rdy),
        .chksum         (chksum)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Image byte b is ((b+1)*17) mod 256: byte 0..7 = 11,22,..,88.
    function automatic logic [7:0] img_byte(input int b);
        return 8'((b + 1) * 17);
    endfunction

    function automatic logic [63:0] img_word(input int w);
        logic [63:0] v;
        v = '0;
        for (int k = 0; k < 8; k++) v[8*k +: 8] = img_byte(8 * w + k);
        return v;
    endfunction

    // DDR responder state
    int          busy_cycles = 0;
    bit          busy_seen = 0;
    logic [28:0] busy_addr;
    logic [7:0]  busy_cnt;
    logic [28:0] req_addr[$];
    logic [7:0]  req_cnt[$];
    int          req_words = 0;
    int          beats_left = 0;
    logic [28:0] beat_addr;
    int          gap = 0;
    int          beat_n = 0;
    int          first_beat_cyc = -1;
    int          max_outst = 0;

    // Consumer state
    int          rdy_mode = 0;
    int          exp_addr = 0;
    int          bytes_got = 0;
    int          first_we_cyc = -1;
    int          last_acc_cyc = -1;
    int          done_n = 0;
    bit          hold_pending = 0;
    logic [26:0] hold_addr;
    logic [7:0]  hold_data;

    initial begin
        ddr_busy       = 1'b0;
        ddr_dout_ready = 1'b0;
        ddr_dout       = '0;
        forever begin
            @(negedge clk);
            ddr_dout_ready = 1'b0;
            if (beats_left > 0) begin
                if (gap > 0) begin
                    gap--;
                end else begin
                    ddr_dout_ready = 1'b1;
                    ddr_dout       = img_word(int'(beat_addr - Base));
                    beat_addr++;
                    beats_left--;
                    beat_n++;
                    if (first_beat_cyc < 0) first_beat_cyc = cyc;
                end
            end
            ddr_busy = 1'b0;
            if (ddrld_rd) begin
                if (busy_cycles > 0) begin
                    ddr_busy = 1'b1;
                    busy_cycles--;
                    if (!busy_seen) begin
                        busy_seen = 1;
                        busy_addr = ddrld_addr;
                        busy_cnt  = ddrld_burstcnt;
                    end else begin
                        check_val("busy_addr_stable", 64'(ddrld_addr), 64'(busy_addr));
                        check_val("busy_cnt_stable", 64'(ddrld_burstcnt), 64'(busy_cnt));
                    end
                end else begin
                    if (busy_seen) begin
                        check_val("accept_addr_stable", 64'(ddrld_addr), 64'(busy_addr));
                        check_val("accept_cnt_stable", 64'(ddrld_burstcnt), 64'(busy_cnt));
                        busy_seen = 0;
                    end
                    req_addr.push_back(ddrld_addr);
                    req_cnt.push_back(ddrld_burstcnt);
                    req_words += int'(ddrld_burstcnt);
                    beats_left = int'(ddrld_burstcnt);
                    beat_addr  = ddrld_addr;
                    gap        = 1;
                    if (req_words - bytes_got / 8 > max_outst) max_outst = req_words - bytes_got / 8;
                end
            end
        end
    end

    initial begin
        prog_rdy = 1'b0;
        forever begin
            @(negedge clk);
            if (hold_pending) begin
                check_val("hold_we", 64'(prog_we), 64'd1);
                check_val("hold_addr", 64'(prog_addr), 64'(hold_addr));
                check_val("hold_data", 64'(prog_data), 64'(hold_data));
            end
            hold_pending = 0;
            prog_rdy = (rdy_mode == 0) ? 1'b1 : cyc[0];
            if (done) done_n++;
            if (prog_we) begin
                if (first_we_cyc < 0) first_we_cyc = cyc;
                if (prog_rdy) begin
                    check_val("prog_addr", 64'(prog_addr), 64'(exp_addr));
                    check_val("prog_data", 64'(prog_data), 64'(img_byte(exp_addr)));
                    exp_addr++;
                    bytes_got++;
                    last_acc_cyc = cyc;
                end else begin
                    hold_pending = 1;
                    hold_addr    = prog_addr;
                    hold_data    = prog_data;
                end
            end
        end
    end

    task automatic clear_trk();
        req_addr.delete();
        req_cnt.delete();
        req_words      = 0;
        beat_n         = 0;
        first_beat_cyc = -1;
        max_outst      = 0;
        exp_addr       = 0;
        bytes_got      = 0;
        first_we_cyc   = -1;
        last_acc_cyc   = -1;
        done_n         = 0;
    endtask

    task automatic do_start(input logic [26:0] l);
        len   = l;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int k = 0;
        while (!done && k < budget) begin
            @(negedge clk);
            k++;
        end
        check_val({tag, "_done_seen"}, 64'(done), 64'd1);
        check_val({tag, "_done_latency"}, 64'(cyc - last_acc_cyc), 64'd1);
        check_val({tag, "_dl_low_at_done"}, 64'(downloading), 64'd0);
    endtask

    task automatic check_idle_outputs(input string tag);
        check_val({tag, "_downloading"}, 64'(downloading), 64'd0);
        check_val({tag, "_done"}, 64'(done), 64'd0);
        check_val({tag, "_rd"}, 64'(ddrld_rd), 64'd0);
        check_val({tag, "_addr"}, 64'(ddrld_addr), 64'(Base));
        check_val({tag, "_burstcnt"}, 64'(ddrld_burstcnt), 64'd0);
        check_val({tag, "_be"}, 64'(ddrld_be), 64'hFF);
        check_val({tag, "_prog_we"}, 64'(prog_we), 64'd0);
        check_val({tag, "_prog_addr"}, 64'(prog_addr), 64'd0);
        check_val({tag, "_chksum"}, 64'(chksum), 64'd0);
    endtask

    logic [15:0] exp_sum5, exp_sum16;

    initial begin
`ifdef JTFRAME_DDRLOAD_CHKSUM_EN
        exp_sum5  = 16'h00FF;
        exp_sum16 = 16'h0808;
`else
        exp_sum5  = 16'h0000;
        exp_sum16 = 16'h0000;
`endif
        rst   = 1'b1;
        start = 1'b0;
        len   = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_idle_outputs("reset");
        check_val("reset_prog_data", 64'(prog_data), 64'd0);

        // Single short image
        clear_trk();
        do_start(27'd5);
        check_val("short_dl_n1", 64'(downloading), 64'd1);
        check_val("short_rd_n1", 64'(ddrld_rd), 64'd1);
        wait_done("short", 100);
        check_val("short_bytes", 64'(bytes_got), 64'd5);
        check_val("short_req_n", 64'(req_addr.size()), 64'd1);
        if (req_addr.size() > 0) begin
            check_val("short_req_addr", 64'(req_addr[0]), 64'(Base));
            check_val("short_req_cnt", 64'(req_cnt[0]), 64'd1);
        end
        check_val("short_first_we_lat", 64'(first_we_cyc - first_beat_cyc), 64'd2);
        check_val("short_throughput", 64'(last_acc_cyc - first_we_cyc), 64'd4);
        check_val("short_chksum", 64'(chksum), 64'(exp_sum5));
        @(negedge clk);
        check_val("short_done_pulse", 64'(done), 64'd0);

        // Multi-burst, with a start while busy that must be ignored
        clear_trk();
        do_start(27'd200);
        repeat (20) @(negedge clk);
        check_val("multi_dl_mid", 64'(downloading), 64'd1);
        do_start(27'd3);
        wait_done("multi", 2000);
        check_val("multi_bytes", 64'(bytes_got), 64'd200);
        check_val("multi_req_n", 64'(req_addr.size()), 64'd4);
        if (req_addr.size() == 4) begin
            for (int i = 0; i < 4; i++) begin
                check_val("multi_req_addr", 64'(req_addr[i]), 64'(Base + 29'(8 * i)));
                check_val("multi_req_cnt", 64'(req_cnt[i]), (i == 3) ? 64'd1 : 64'd8);
            end
        end
        repeat (5) @(negedge clk);
        check_val("multi_done_count", 64'(done_n), 64'd1);
        check_val("multi_no_restart", 64'(ddrld_rd | downloading), 64'd0);

        // Waitrequest held for 5 cycles
        clear_trk();
        busy_cycles = 5;
        busy_seen   = 0;
        do_start(27'd16);
        wait_done("busy", 300);
        check_val("busy_req_n", 64'(req_addr.size()), 64'd1);
        if (req_cnt.size() > 0) check_val("busy_req_cnt", 64'(req_cnt[0]), 64'd2);
        check_val("busy_bytes", 64'(bytes_got), 64'd16);

        // Back-pressure: prog_rdy every other cycle
        clear_trk();
        rdy_mode = 1;
        do_start(27'd200);
        wait_done("bp", 3000);
        check_val("bp_bytes", 64'(bytes_got), 64'd200);
        check_val("bp_req_words", 64'(req_words), 64'd25);
        check_val("bp_outst_bounded", 64'(max_outst <= 17), 64'd1);
        check_val("bp_fifo_filled", 64'(max_outst > 8), 64'd1);
        rdy_mode = 0;
        repeat (2) @(negedge clk);

        // len == 0
        clear_trk();
        do_start(27'd0);
        check_val("zero_done", 64'(done), 64'd1);
        check_val("zero_dl", 64'(downloading), 64'd0);
        repeat (4) @(negedge clk);
        check_val("zero_req_n", 64'(req_addr.size()), 64'd0);
        check_val("zero_done_count", 64'(done_n), 64'd1);

        // Reset mid-burst
        clear_trk();
        do_start(27'd64);
        begin
            int k = 0;
            while (beat_n < 3 && k < 100) begin
                @(negedge clk);
                k++;
            end
            check_val("rst_beats_reached", 64'(beat_n >= 3), 64'd1);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_idle_outputs("midrst");
        bytes_got = 0;
        done_n    = 0;
        begin
            int k = 0;
            while (beats_left > 0 && k < 100) begin
                @(negedge clk);
                k++;
            end
        end
        repeat (4) @(negedge clk);
        check_val("midrst_no_bytes", 64'(bytes_got), 64'd0);
        check_val("midrst_no_done", 64'(done_n), 64'd0);
        check_val("midrst_dl", 64'(downloading), 64'd0);
        clear_trk();
        do_start(27'd16);
        wait_done("after_rst", 300);
        check_val("after_rst_bytes", 64'(bytes_got), 64'd16);
        check_val("after_rst_req_n", 64'(req_addr.size()), 64'd1);
        if (req_addr.size() > 0) begin
            check_val("after_rst_req_addr", 64'(req_addr[0]), 64'(Base));
            check_val("after_rst_req_cnt", 64'(req_cnt[0]), 64'd2);
        end
        check_val("after_rst_chksum", 64'(chksum), 64'(exp_sum16));

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1, "timeout");
    end

endmodule
